// File: rtl/uart_cmd_parser.sv
// ASCII register-access command interpreter: pops a line from the UART RX FIFO,
// performs "W aa dd" / "R aa" on the register bus and pushes a 4-byte reply.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 27000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_fifo_empty,
  input  logic [7:0] rx_fifo_data,
  output logic       rx_fifo_rd_en,
  input  logic       tx_fifo_full,
  output logic [7:0] tx_fifo_data,
  output logic       tx_fifo_wr_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       cmd_error
);

  typedef enum logic [2:0] {S_IDLE, S_ARGS, S_EXEC, S_RDWAIT, S_RESP} state_t;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
  localparam logic [31:0] RESP_OK = {8'h4F, 8'h4B, 8'h0D, 8'h0A};
  localparam logic [31:0] RESP_ER = {8'h45, 8'h52, 8'h0D, 8'h0A};

  state_t      state_reg;
  logic        is_wr_reg;
  logic        err_reg;
  logic        rd_phase_reg;
  logic [2:0]  cnt_reg;
  logic [15:0] acc_reg;
  logic [31:0] idle_cnt_reg;
  logic [31:0] resp_reg;
  logic [1:0]  resp_idx_reg;

  logic [2:0]  need;
  logic        can_pop;
  logic        is_term;
  logic        is_space;
  logic        is_hex;
  logic [3:0]  nib;

  function automatic logic [7:0] hex_chr(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  assign need     = is_wr_reg ? 3'd4 : 3'd2;
  // A pop is never issued back-to-back, so the FIFO has a cycle to advance its head.
  assign can_pop  = !rx_fifo_empty && !rx_fifo_rd_en;
  assign is_term  = (rx_fifo_data == 8'h0D) || (rx_fifo_data == 8'h0A);
  assign is_space = (rx_fifo_data == 8'h20);
  assign is_hex   = ((rx_fifo_data >= 8'h30) && (rx_fifo_data <= 8'h39)) ||
                    ((rx_fifo_data >= 8'h41) && (rx_fifo_data <= 8'h46)) ||
                    ((rx_fifo_data >= 8'h61) && (rx_fifo_data <= 8'h66));
  assign nib      = (rx_fifo_data <= 8'h39) ? rx_fifo_data[3:0] : (rx_fifo_data[3:0] + 4'd9);
  assign busy     = (state_reg != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      is_wr_reg     <= 1'b0;
      err_reg       <= 1'b0;
      rd_phase_reg  <= 1'b0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      idle_cnt_reg  <= '0;
      resp_reg      <= '0;
      resp_idx_reg  <= '0;
      rx_fifo_rd_en <= 1'b0;
      tx_fifo_data  <= '0;
      tx_fifo_wr_en <= 1'b0;
      reg_addr      <= '0;
      reg_wdata     <= '0;
      reg_wr        <= 1'b0;
      reg_rd        <= 1'b0;
      cmd_error     <= 1'b0;
    end else begin
      rx_fifo_rd_en <= 1'b0;
      tx_fifo_wr_en <= 1'b0;
      reg_wr        <= 1'b0;
      reg_rd        <= 1'b0;
      cmd_error     <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (can_pop) begin
            rx_fifo_rd_en <= 1'b1;
            idle_cnt_reg  <= '0;
            if (!is_term && !is_space) begin
              state_reg <= S_ARGS;
              cnt_reg   <= '0;
              acc_reg   <= '0;
              is_wr_reg <= (rx_fifo_data == 8'h57) || (rx_fifo_data == 8'h77);
              err_reg   <= !((rx_fifo_data == 8'h57) || (rx_fifo_data == 8'h77) ||
                             (rx_fifo_data == 8'h52) || (rx_fifo_data == 8'h72));
            end
          end
        end
        S_ARGS: begin
          if (can_pop) begin
            rx_fifo_rd_en <= 1'b1;
            idle_cnt_reg  <= '0;
            if (is_term) begin
              state_reg <= S_EXEC;
            end else if (is_hex) begin
              if (cnt_reg == need) begin
                err_reg <= 1'b1;
              end else begin
                acc_reg <= {acc_reg[11:0], nib};
                cnt_reg <= cnt_reg + 3'd1;
              end
            end else if (!is_space) begin
              err_reg <= 1'b1;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            // A stalled partial line is dropped silently.
            if (idle_cnt_reg == TIMEOUT_LAST) begin
              state_reg    <= S_IDLE;
              idle_cnt_reg <= '0;
            end else begin
              idle_cnt_reg <= idle_cnt_reg + 32'd1;
            end
          end
        end
        S_EXEC: begin
          resp_idx_reg <= '0;
          if (err_reg || (cnt_reg != need)) begin
            resp_reg  <= RESP_ER;
            cmd_error <= 1'b1;
            state_reg <= S_RESP;
          end else if (is_wr_reg) begin
            reg_addr  <= acc_reg[15:8];
            reg_wdata <= acc_reg[7:0];
            reg_wr    <= 1'b1;
            resp_reg  <= RESP_OK;
            state_reg <= S_RESP;
          end else begin
            reg_addr     <= acc_reg[7:0];
            reg_rd       <= 1'b1;
            rd_phase_reg <= 1'b0;
            state_reg    <= S_RDWAIT;
          end
        end
        S_RDWAIT: begin
          // Read data lands one cycle after the strobe cycle.
          if (!rd_phase_reg) begin
            rd_phase_reg <= 1'b1;
          end else begin
            resp_reg  <= {hex_chr(reg_rdata[7:4]), hex_chr(reg_rdata[3:0]), 8'h0D, 8'h0A};
            state_reg <= S_RESP;
          end
        end
        S_RESP: begin
          if (!tx_fifo_full) begin
            tx_fifo_wr_en <= 1'b1;
            tx_fifo_data  <= resp_reg[31:24];
            resp_reg      <= {resp_reg[23:0], 8'h00};
            resp_idx_reg  <= resp_idx_reg + 2'd1;
            if (resp_idx_reg == 2'd3) state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: directed and random command lines are fed through
// a modelled RX FIFO; a line-level reference model queues expected bus ops and reply bytes.
module tb_uart_cmd_parser;

  localparam int unsigned TO_CYC = 100;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_fifo_empty = 1'b1;
  logic [7:0] rx_fifo_data = 8'h00;
  logic       rx_fifo_rd_en;
  logic       tx_fifo_full = 1'b0;
  logic [7:0] tx_fifo_data;
  logic       tx_fifo_wr_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic       cmd_error;

  uart_cmd_parser #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clock(clock), .reset(reset),
    .rx_fifo_empty(rx_fifo_empty), .rx_fifo_data(rx_fifo_data), .rx_fifo_rd_en(rx_fifo_rd_en),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_data(tx_fifo_data), .tx_fifo_wr_en(tx_fifo_wr_en),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .busy(busy), .cmd_error(cmd_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
  } reg_op_t;

  logic [7:0] rxq[$];
  logic [7:0] exp_tx[$];
  reg_op_t    exp_reg[$];
  logic [7:0] lb[$];
  logic [7:0] bus_mem[256];
  logic [7:0] mdl_mem[256];

  int n_assert = 0;
  int n_fail   = 0;
  int exp_err  = 0;
  int got_err  = 0;
  int tx_cnt   = 0;
  int full_mode = 0;
  bit full_prev = 1'b0;
  bit mem_init  = 1'b0;

  // Reference model state: one command line at a time.
  bit         m_in_line = 1'b0;
  logic [7:0] m_cmd;
  bit         m_err;
  int         m_nd;
  int         m_val;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 37 + 91) & 255);
  endfunction

  function automatic logic [7:0] hexch(input int n, input bit lower);
    if (n < 10) return 8'(48 + n);
    return lower ? 8'(87 + n) : 8'(55 + n);
  endfunction

  function automatic int hexval(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
    if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
    if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
    return -1;
  endfunction

  task automatic push_reply(input logic [7:0] a, input logic [7:0] b);
    exp_tx.push_back(a);
    exp_tx.push_back(b);
    exp_tx.push_back(8'h0D);
    exp_tx.push_back(8'h0A);
  endtask

  task automatic model_finish();
    bit      is_w = (m_cmd == 8'h57) || (m_cmd == 8'h77);
    int      need = is_w ? 4 : 2;
    reg_op_t op;
    logic [7:0] d;
    if (m_err || m_nd != need) begin
      push_reply(8'h45, 8'h52);
      exp_err++;
    end else if (is_w) begin
      op.wr = 1'b1;
      op.addr = 8'(m_val / 256);
      op.data = 8'(m_val % 256);
      exp_reg.push_back(op);
      mdl_mem[op.addr] = op.data;
      push_reply(8'h4F, 8'h4B);
    end else begin
      op.wr = 1'b0;
      op.addr = 8'(m_val);
      op.data = 8'h00;
      exp_reg.push_back(op);
      d = mdl_mem[op.addr];
      push_reply(hexch(int'(d) / 16, 1'b0), hexch(int'(d) % 16, 1'b0));
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit is_t = (b == 8'h0D) || (b == 8'h0A);
    int hv = hexval(b);
    if (!m_in_line) begin
      if (!is_t && b != 8'h20) begin
        m_in_line = 1'b1;
        m_cmd = b;
        m_err = !(b == 8'h57 || b == 8'h77 || b == 8'h52 || b == 8'h72);
        m_nd = 0;
        m_val = 0;
      end
    end else if (is_t) begin
      model_finish();
      m_in_line = 1'b0;
    end else if (b != 8'h20) begin
      if (hv >= 0) begin
        m_nd++;
        m_val = (m_val * 16 + hv) % 65536;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic put(input logic [7:0] b);
    lb.push_back(b);
  endtask

  task automatic put_sp();
    repeat ($urandom_range(0, 2)) put(8'h20);
  endtask

  task automatic put_hex(input logic [7:0] v);
    put(hexch(int'(v[7:4]), 1'($urandom_range(0, 1))));
    put(hexch(int'(v[3:0]), 1'($urandom_range(0, 1))));
  endtask

  task automatic flush_line();
    foreach (lb[i]) begin
      rxq.push_back(lb[i]);
      model_byte(lb[i]);
    end
    lb.delete();
  endtask

  task automatic send_cmd(input string s, input logic [7:0] term);
    for (int i = 0; i < s.len(); i++) put(s[i]);
    put(term);
    flush_line();
  endtask

  task automatic send_partial(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
    flush_line();
  endtask

  task automatic rand_line();
    int kind = $urandom_range(0, 9);
    logic [7:0] a = 8'($urandom);
    logic [7:0] d = 8'($urandom);
    int n;
    put_sp();
    case (kind)
      0, 1, 2, 3: begin
        put($urandom_range(0, 1) ? 8'h57 : 8'h77);
        put_sp(); put_hex(a); put_sp(); put_hex(d); put_sp();
      end
      4, 5, 6: begin
        put($urandom_range(0, 1) ? 8'h52 : 8'h72);
        put_sp(); put_hex(a); put_sp();
      end
      7: ;
      8: begin
        put(8'(8'h41 + $urandom_range(0, 25)));
        put_sp(); put_hex(a);
      end
      default: begin
        put($urandom_range(0, 1) ? 8'h52 : 8'h57);
        n = $urandom_range(0, 6);
        for (int i = 0; i < n; i++)
          put(($urandom_range(0, 7) == 0) ? 8'h47 : hexch($urandom_range(0, 15), 1'($urandom_range(0, 1))));
      end
    endcase
    put($urandom_range(0, 1) ? 8'h0D : 8'h0A);
    if ($urandom_range(0, 3) == 0) put(8'h0A);
    flush_line();
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clock);
      done = (rxq.size() == 0) && (exp_tx.size() == 0) && !busy;
    end
    check({tag, "_drain"}, 32'(done), 32'd1);
    repeat (6) @(negedge clock);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rd_en"}, 32'(rx_fifo_rd_en), 32'd0);
    check({tag, "_wr_en"}, 32'(tx_fifo_wr_en), 32'd0);
    check({tag, "_strobes"}, {29'd0, reg_wr, reg_rd, cmd_error}, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // RX FIFO model with first-word fall-through; pops on the cycle rd_en is high.
  always @(posedge clock) begin
    if (rx_fifo_rd_en && rxq.size() > 0) void'(rxq.pop_front());
    rx_fifo_empty <= (rxq.size() == 0);
    rx_fifo_data  <= (rxq.size() > 0) ? rxq[0] : 8'h00;
  end

  // Register bus: read data is only meaningful the cycle after reg_rd.
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) bus_mem[i] <= init_val(i);
    end else if (reg_wr) begin
      bus_mem[reg_addr] <= reg_wdata;
    end
    reg_rdata <= reg_rd ? bus_mem[reg_addr] : 8'($urandom);
  end

  always @(posedge clock) begin
    #2;
    case (full_mode)
      1:       tx_fifo_full = ($urandom_range(0, 3) == 0);
      2:       tx_fifo_full = 1'b1;
      default: tx_fifo_full = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard whenever the DUT presents a push or bus strobe.
  always @(negedge clock) begin
    reg_op_t e;
    logic [7:0] et;
    if (tx_fifo_wr_en) begin
      tx_cnt++;
      check("tx_push_while_full", 32'(full_prev), 32'd0);
      check("tx_byte_expected", 32'(exp_tx.size() != 0), 32'd1);
      if (exp_tx.size() != 0) begin
        et = exp_tx.pop_front();
        $display("tx byte %02h expected %02h", tx_fifo_data, et);
        check("tx_data", 32'(tx_fifo_data), 32'(et));
      end
    end
    if (reg_wr || reg_rd) begin
      check("reg_single_strobe", 32'(reg_wr && reg_rd), 32'd0);
      check("reg_op_expected", 32'(exp_reg.size() != 0), 32'd1);
      if (exp_reg.size() != 0) begin
        e = exp_reg.pop_front();
        $display("reg %s addr %02h data %02h", reg_wr ? "wr" : "rd", reg_addr, reg_wdata);
        check("reg_is_write", 32'(reg_wr), 32'(e.wr));
        check("reg_addr", 32'(reg_addr), 32'(e.addr));
        if (e.wr) check("reg_wdata", 32'(reg_wdata), 32'(e.data));
      end
    end
    if (rx_fifo_rd_en) check("rx_pop_nonempty", 32'(rx_fifo_empty), 32'd0);
    if (cmd_error) got_err++;
    full_prev = tx_fifo_full;
  end

  initial begin
    int c0;
    bit seen;
    string errs[4];
    errs[0] = "W 1A"; errs[1] = "X12"; errs[2] = "R 1G"; errs[3] = "R 123";
    for (int i = 0; i < 256; i++) mdl_mem[i] = init_val(i);

    reset = 1'b1;
    mem_init = 1'b1;
    repeat (3) @(negedge clock);
    check_quiet("reset");
    check("reset_tx_data", 32'(tx_fifo_data), 32'd0);
    check("reset_reg_addr", {16'd0, reg_addr, reg_wdata}, 32'd0);
    mem_init = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);

    send_cmd("W 1A 5C", 8'h0D);
    send_cmd("W 1A E7", 8'h0A);
    send_cmd("r 1a", 8'h0A);
    drain("basic");

    put(8'h0D); put(8'h0A); put(8'h0D); put(8'h0A); flush_line();
    send_cmd("R05", 8'h0D);
    drain("blank");

    foreach (errs[i]) send_cmd(errs[i], 8'h0D);
    drain("errors");
    check("err_pulses_directed", 32'(got_err), 32'(exp_err));

    // Back-pressure: hold the TX FIFO full for 20 cycles once the reply has started.
    c0 = tx_cnt;
    send_cmd("R 05", 8'h0D);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      seen = (tx_cnt != c0);
    end
    check("resp_started", 32'(seen), 32'd1);
    full_mode = 2;
    repeat (3) @(negedge clock);
    c0 = tx_cnt;
    repeat (17) @(negedge clock);
    check("no_push_while_full", 32'(tx_cnt), 32'(c0));
    full_mode = 0;
    drain("backpressure");

    // Partial line abandoned by the timeout.
    send_partial("W 1");
    repeat (50) @(negedge clock);
    check("timeout_not_early", 32'(busy), 32'd1);
    repeat (100) @(negedge clock);
    check("timeout_idle", 32'(busy), 32'd0);
    m_in_line = 1'b0;
    send_cmd("R 02", 8'h0D);
    drain("timeout");

    // Reset in the middle of an argument list.
    send_partial("W 12");
    for (int i = 0; i < 100 && rxq.size() != 0; i++) @(negedge clock);
    repeat (4) @(negedge clock);
    check("mid_args_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_quiet("mid_reset");
    m_in_line = 1'b0;
    send_cmd("R 02", 8'h0D);
    drain("after_reset");

    full_mode = 1;
    for (int i = 0; i < 60; i++) rand_line();
    drain("random");
    full_mode = 0;
    repeat (4) @(negedge clock);

    check("err_pulses_total", 32'(got_err), 32'(exp_err));
    check("reg_ops_left", 32'(exp_reg.size()), 32'd0);
    check("tx_bytes_left", 32'(exp_tx.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
